// File: rtl/pico_sim.sv
// Stream classifier: words whose low-bit key is divisible by a bus-programmable divisor go to
// stream 2, all others to stream 1, each through a first-word-fall-through FIFO.

module pico_sim_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic [W-1:0] push_dat_i,
   output logic         full_o,
   output logic         pop_vld_o,
   input  logic         pop_rdy_i,
   output logic [W-1:0] pop_dat_o
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wptr_q, rptr_q;
   logic         pop, do_push;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign pop_vld_o = (wptr_q != rptr_q);
   assign pop_dat_o = mem_q[rptr_q[AW-1:0]];
   assign pop       = pop_vld_o & pop_rdy_i;
   assign do_push   = push_i & (~full_o | pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + {{AW{1'b0}}, 1'b1};
         if (pop)     rptr_q <= rptr_q + {{AW{1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= push_dat_i;
   end
endmodule

module pico_sim #(
   parameter int DATA_W     = 128,
   parameter int NUM_BITS   = 4,
   parameter int FIFO_DEPTH = 16,
   parameter int DIV_RESET  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pb_wr,
   input  logic              pb_rd,
   input  logic [31:0]       pb_addr,
   input  logic [31:0]       pb_din,
   output logic [31:0]       pb_dout,
   output logic              pb_dout_valid,
   input  logic              s1i_valid,
   output logic              s1i_rdy,
   input  logic [DATA_W-1:0] s1i_data,
   output logic              s1o_valid,
   input  logic              s1o_rdy,
   output logic [DATA_W-1:0] s1o_data,
   output logic              s2o_valid,
   input  logic              s2o_rdy,
   output logic [DATA_W-1:0] s2o_data
);
   localparam logic [31:0] ADDR_DIV  = 32'h00;
   localparam logic [31:0] ADDR_DCNT = 32'h10;
   localparam logic [31:0] ADDR_NCNT = 32'h14;

   logic [31:0] divisor_q, divisor_d;
   logic [31:0] div_cnt_q, div_cnt_d;
   logic [31:0] ndiv_cnt_q, ndiv_cnt_d;
   logic [31:0] dout_q, dout_d;
   logic        dout_vld_q;
   logic        rdy_en_q;
   logic        full1, full2;
   logic        accept, is_div;
   logic [31:0] key;

   assign s1i_rdy       = rdy_en_q & ~full1 & ~full2;
   assign accept        = s1i_valid & s1i_rdy;
   assign pb_dout       = dout_q;
   assign pb_dout_valid = dout_vld_q;

   // A divisor wider than the key can only divide zero, so the remainder is only
   // ever computed at key width.
   always_comb begin
      key                 = '0;
      key[NUM_BITS-1:0]   = s1i_data[NUM_BITS-1:0];
      is_div              = 1'b0;
      if (divisor_q == '0)
         is_div = 1'b0;
      else if (divisor_q > key)
         is_div = (key == '0);
      else
         is_div = ((key[NUM_BITS-1:0] % divisor_q[NUM_BITS-1:0]) == '0);
   end

   always_comb begin
      divisor_d  = divisor_q;
      div_cnt_d  = div_cnt_q;
      ndiv_cnt_d = ndiv_cnt_q;
      dout_d     = dout_q;
      if (pb_wr && pb_addr == ADDR_DIV) divisor_d = pb_din;
      if (accept && is_div)  div_cnt_d  = div_cnt_q + 32'd1;
      if (accept && !is_div) ndiv_cnt_d = ndiv_cnt_q + 32'd1;
      if (pb_rd) begin
         case (pb_addr)
            ADDR_DIV:  dout_d = divisor_q;
            ADDR_DCNT: dout_d = div_cnt_q;
            ADDR_NCNT: dout_d = ndiv_cnt_q;
            default:   dout_d = '0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         divisor_q  <= 32'(DIV_RESET);
         div_cnt_q  <= '0;
         ndiv_cnt_q <= '0;
         dout_q     <= '0;
         dout_vld_q <= 1'b0;
         rdy_en_q   <= 1'b0;
      end else begin
         divisor_q  <= divisor_d;
         div_cnt_q  <= div_cnt_d;
         ndiv_cnt_q <= ndiv_cnt_d;
         dout_q     <= dout_d;
         dout_vld_q <= pb_rd;
         rdy_en_q   <= 1'b1;
      end
   end

   pico_sim_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo1 (
      .clk        (clk),
      .rst        (rst),
      .push_i     (accept & ~is_div),
      .push_dat_i (s1i_data),
      .full_o     (full1),
      .pop_vld_o  (s1o_valid),
      .pop_rdy_i  (s1o_rdy),
      .pop_dat_o  (s1o_data)
   );

   pico_sim_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo2 (
      .clk        (clk),
      .rst        (rst),
      .push_i     (accept & is_div),
      .push_dat_i (s1i_data),
      .full_o     (full2),
      .pop_vld_o  (s2o_valid),
      .pop_rdy_i  (s2o_rdy),
      .pop_dat_o  (s2o_data)
   );
endmodule

// File: tb/tb_pico_sim.sv
// Scoreboard bench for pico_sim: expected words queued at input acceptance, popped at output.

module tb_pico_sim;
   localparam int DATA_W = 128;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              pb_wr = 1'b0, pb_rd = 1'b0;
   logic [31:0]       pb_addr = '0, pb_din = '0;
   logic [31:0]       pb_dout;
   logic              pb_dout_valid;
   logic              s1i_valid = 1'b0;
   logic              s1i_rdy;
   logic [DATA_W-1:0] s1i_data = '0;
   logic              s1o_valid, s2o_valid;
   logic              s1o_rdy = 1'b1, s2o_rdy = 1'b1;
   logic [DATA_W-1:0] s1o_data, s2o_data;

   int checks = 0;
   int failures = 0;
   int tb_div = 2;
   bit s2_seen = 1'b0;
   int n_pop2 = 0;
   logic [DATA_W-1:0] q1[$];
   logic [DATA_W-1:0] q2[$];

   pico_sim dut (
      .clk(clk), .rst(rst),
      .pb_wr(pb_wr), .pb_rd(pb_rd), .pb_addr(pb_addr), .pb_din(pb_din),
      .pb_dout(pb_dout), .pb_dout_valid(pb_dout_valid),
      .s1i_valid(s1i_valid), .s1i_rdy(s1i_rdy), .s1i_data(s1i_data),
      .s1o_valid(s1o_valid), .s1o_rdy(s1o_rdy), .s1o_data(s1o_data),
      .s2o_valid(s2o_valid), .s2o_rdy(s2o_rdy), .s2o_data(s2o_data)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [DATA_W-1:0] got,
                           input logic [DATA_W-1:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic bit model_div(input logic [DATA_W-1:0] d);
      int key;
      key = int'(d[3:0]);
      if (tb_div == 0) return 1'b0;
      return (key % tb_div) == 0;
   endfunction

   // Handshakes seen at the falling edge complete on the following rising edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (s1i_valid && s1i_rdy) begin
            if (model_div(s1i_data)) q2.push_back(s1i_data);
            else                     q1.push_back(s1i_data);
         end
         if (s2o_valid) s2_seen = 1'b1;
         if (s1o_valid && s1o_rdy) begin
            if (q1.size() == 0) check_eq("s1_extra", 1, 0);
            else                check_eq("s1_data", s1o_data, q1.pop_front());
         end
         if (s2o_valid && s2o_rdy) begin
            n_pop2++;
            if (q2.size() == 0) check_eq("s2_extra", 1, 0);
            else                check_eq("s2_data", s2o_data, q2.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [DATA_W-1:0] w);
      bit ok;
      ok = 1'b0;
      s1i_valid = 1'b1;
      s1i_data  = w;
      for (int c = 0; c < 500 && !ok; c++) begin
         @(negedge clk);
         ok = s1i_rdy;
         step();
      end
      s1i_valid = 1'b0;
      if (!ok) check_eq("send_timeout", 0, 1);
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
      pb_wr = 1'b1; pb_addr = a; pb_din = d;
      step();
      pb_wr = 1'b0;
      if (a == 32'h0) tb_div = int'(d);
   endtask

   task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
      pb_rd = 1'b1; pb_addr = a;
      step();
      pb_rd = 1'b0;
      check_eq({tag, "_vld"}, pb_dout_valid, 1);
      check_eq(tag, pb_dout, exp);
      step();
   endtask

   task automatic drain();
      for (int c = 0; c < 3000 && (q1.size() + q2.size()) != 0; c++) step();
      check_eq("drain_left", q1.size() + q2.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx;
      logic [DATA_W-1:0] big;

      // Reset state
      step(); step();
      check_eq("rst_s1o_vld", s1o_valid, 0);
      check_eq("rst_s2o_vld", s2o_valid, 0);
      check_eq("rst_rdy", s1i_rdy, 0);
      check_eq("rst_dout_vld", pb_dout_valid, 0);
      check_eq("rst_dout", pb_dout, 0);
      rst = 1'b0;
      step();
      check_eq("rdy_after_rst", s1i_rdy, 1);
      read_chk("div_rst", 32'h00, 2);
      read_chk("dcnt_rst", 32'h10, 0);
      read_chk("ncnt_rst", 32'h14, 0);

      // Divisor 2, words 0..255
      for (int i = 0; i < 256; i++) send(DATA_W'(i));
      drain();
      read_chk("dcnt_a", 32'h10, 128);
      read_chk("ncnt_a", 32'h14, 128);

      // Divisor 3: wide word with key 3, then 0..15
      bus_wr(32'h00, 3);
      read_chk("div_3", 32'h00, 3);
      big = {32'hA5A5_1234, 32'hDEAD_BEEF, 32'h0F0F_F0F0, 32'h8765_0013};
      send(big);
      check_eq("lat_s2o_vld", s2o_valid, 1);
      check_eq("lat_s2o_dat", s2o_data, big);
      check_eq("lat_s1o_vld", s1o_valid, 0);
      for (int i = 0; i < 16; i++) send(DATA_W'(i));
      drain();
      bus_wr(32'h10, 32'h1234);
      bus_wr(32'h14, 32'h1234);
      read_chk("dcnt_b", 32'h10, 135);
      read_chk("ncnt_b", 32'h14, 138);
      read_chk("unmapped", 32'h08, 0);

      // Divisor 0: everything non-divisible
      bus_wr(32'h00, 0);
      s2_seen = 1'b0;
      for (int i = 0; i < 8; i++) send(DATA_W'(i));
      drain();
      check_eq("div0_s2_seen", s2_seen, 0);
      read_chk("ncnt_c", 32'h14, 146);

      // Backpressure: stream 2 blocked, 40 even words
      bus_wr(32'h00, 2);
      s2o_rdy = 1'b0;
      n_pop2 = 0;
      idx = 0;
      s1i_valid = 1'b1;
      s1i_data = '0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (s1i_rdy) idx++;
         step();
         s1i_data = DATA_W'(idx * 2);
      end
      check_eq("bp_accepted", idx, 16);
      check_eq("bp_rdy_low", s1i_rdy, 0);
      s2o_rdy = 1'b1;
      for (int c = 0; c < 500 && idx < 40; c++) begin
         @(negedge clk);
         if (s1i_rdy) idx++;
         step();
         s1i_data = DATA_W'(idx * 2);
      end
      s1i_valid = 1'b0;
      check_eq("bp_total", idx, 40);
      drain();
      check_eq("bp_popped", n_pop2, 40);
      read_chk("dcnt_d", 32'h10, 175);

      // Reset with words buffered
      bus_wr(32'h00, 7);
      s1o_rdy = 1'b0;
      s2o_rdy = 1'b0;
      for (int i = 1; i <= 5; i++) send(DATA_W'(i));
      check_eq("pre_rst_s1o_vld", s1o_valid, 1);
      rst = 1'b1;
      step(); step();
      q1.delete();
      q2.delete();
      tb_div = 2;
      check_eq("mid_rst_s1o_vld", s1o_valid, 0);
      check_eq("mid_rst_s2o_vld", s2o_valid, 0);
      check_eq("mid_rst_rdy", s1i_rdy, 0);
      rst = 1'b0;
      s1o_rdy = 1'b1;
      s2o_rdy = 1'b1;
      step();
      check_eq("post_rst_rdy", s1i_rdy, 1);
      read_chk("div_post", 32'h00, 2);
      read_chk("dcnt_post", 32'h10, 0);
      read_chk("ncnt_post", 32'h14, 0);
      check_eq("post_rst_s1o_vld", s1o_valid, 0);
      check_eq("post_rst_s2o_vld", s2o_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
